// File: rtl/priv_pkg.sv
// Shared privilege/trap definitions: privilege encodings, sequencer enums
// and mstatus bit positions used by the trap sequencer.
package priv_pkg;
    localparam logic [1:0] M_MODE = 2'b11;
    localparam logic [1:0] U_MODE = 2'b00;

    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;
    localparam int MPP_LSB  = 11;

    typedef enum logic [1:0] {IDLE, DRAIN, WRITE, REDIRECT} trap_state_e;
    typedef enum logic [1:0] {EXC, IRQ, RET} trap_kind_e;
endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder for masked interrupt requests; lowest index wins.
module irq_prio_enc #(
    parameter int NUM_IRQ = 4,
    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);
    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan downwards so the lowest set bit is the last assignment.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/trap_ctrl.sv
// Privilege and trap sequencer: picks one exception/interrupt/MRET event,
// drains the pipeline, writes the trap CSRs and redirects fetch.
module trap_ctrl
    import priv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IRQ    = 4,
    parameter int IRQ_BASE   = 16,
    parameter bit HAS_U_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exc_valid,
    input  logic [DATA_WIDTH-1:0] exc_cause,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    input  logic [DATA_WIDTH-1:0] exc_tval,
    input  logic                  mret_valid,
    input  logic [DATA_WIDTH-1:0] next_pc,
    input  logic [NUM_IRQ-1:0]    irq_pending,
    input  logic [NUM_IRQ-1:0]    irq_enable,
    input  logic [DATA_WIDTH-1:0] mtvec,
    input  logic [DATA_WIDTH-1:0] mepc,
    input  logic                  drain_done,
    output logic                  flush,
    output logic                  busy,
    output logic                  csr_we,
    output logic [DATA_WIDTH-1:0] mepc_wdata,
    output logic [DATA_WIDTH-1:0] mcause_wdata,
    output logic [DATA_WIDTH-1:0] mtval_wdata,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [1:0]            current_privilege,
    output logic [DATA_WIDTH-1:0] mstatus_out
);
    localparam int         IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [1:0] MPP_RET = HAS_U_MODE ? U_MODE : M_MODE;

    trap_state_e           state, state_next;
    trap_kind_e            kind;
    logic [DATA_WIDTH-1:0] cause_q, pc_q, tval_q;
    logic [1:0]            priv, mpp;
    logic                  mie, mpie;
    logic                  irq_any, irq_take, ev_take;
    logic [IDX_W-1:0]      irq_idx;
    logic [DATA_WIDTH-1:0] irq_code, base, vec_off;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
        .req   (irq_pending & irq_enable),
        .valid (irq_any),
        .idx   (irq_idx)
    );

    // U-mode code can always be preempted by M-level interrupts.
    assign irq_take = irq_any && (mie || priv == U_MODE);
    assign ev_take  = exc_valid || irq_take || mret_valid;
    assign irq_code = DATA_WIDTH'(IRQ_BASE) + DATA_WIDTH'(irq_idx);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (ev_take) state_next = DRAIN;
            DRAIN:    if (drain_done) state_next = (kind == RET) ? REDIRECT : WRITE;
            WRITE:    state_next = REDIRECT;
            REDIRECT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            kind    <= EXC;
            cause_q <= '0;
            pc_q    <= '0;
            tval_q  <= '0;
            priv    <= M_MODE;
            mie     <= 1'b0;
            mpie    <= 1'b0;
            mpp     <= MPP_RET;
        end else begin
            if (state == IDLE) begin
                if (exc_valid) begin
                    kind    <= EXC;
                    cause_q <= exc_cause;
                    pc_q    <= exc_pc;
                    tval_q  <= exc_tval;
                end else if (irq_take) begin
                    kind    <= IRQ;
                    cause_q <= {1'b1, irq_code[DATA_WIDTH-2:0]};
                    pc_q    <= next_pc;
                    tval_q  <= '0;
                end else if (mret_valid) begin
                    kind    <= RET;
                end
            end
            if (state == WRITE) begin
                mpie <= mie;
                mie  <= 1'b0;
                mpp  <= HAS_U_MODE ? priv : M_MODE;
                priv <= M_MODE;
            end
            if (state == REDIRECT && kind == RET) begin
                mie  <= mpie;
                mpie <= 1'b1;
                priv <= mpp;
                mpp  <= MPP_RET;
            end
        end
    end

    assign base    = {mtvec[DATA_WIDTH-1:2], 2'b00};
    assign vec_off = {cause_q[DATA_WIDTH-3:0], 2'b00};

    always_comb begin
        flush          = (state == DRAIN);
        busy           = (state != IDLE);
        csr_we         = (state == WRITE);
        redirect_valid = (state == REDIRECT);
        mepc_wdata     = csr_we ? pc_q    : '0;
        mcause_wdata   = csr_we ? cause_q : '0;
        mtval_wdata    = csr_we ? tval_q  : '0;
        redirect_pc    = '0;
        if (state == REDIRECT) begin
            if (kind == RET)
                redirect_pc = mepc;
            else if (kind == IRQ && mtvec[1:0] == 2'b01)
                redirect_pc = base + vec_off;
            else
                redirect_pc = base;
        end
        mstatus_out                       = '0;
        mstatus_out[MIE_BIT]              = mie;
        mstatus_out[MPIE_BIT]             = mpie;
        mstatus_out[MPP_LSB+1:MPP_LSB]    = mpp;
    end

    assign current_privilege = priv;
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus random events, checked against
// a transaction-level model of privilege state and the trap timeline.
module tb_trap_ctrl;
    localparam int K_NONE = 0, K_EXC = 1, K_IRQ = 2, K_RET = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid, mret_valid, drain_done;
    logic [31:0] exc_cause, exc_pc, exc_tval, next_pc, mtvec, mepc;
    logic [3:0]  irq_pending, irq_enable;
    logic        flush, busy, csr_we, redirect_valid;
    logic [31:0] mepc_wdata, mcause_wdata, mtval_wdata, redirect_pc, mstatus_out;
    logic [1:0]  current_privilege;

    int n_chk = 0;
    int n_fail = 0;

    // model of architectural privilege state
    logic [1:0] m_priv, m_mpp;
    logic       m_mie, m_mpie;

    trap_ctrl dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret_valid(mret_valid), .next_pc(next_pc),
        .irq_pending(irq_pending), .irq_enable(irq_enable),
        .mtvec(mtvec), .mepc(mepc), .drain_done(drain_done),
        .flush(flush), .busy(busy), .csr_we(csr_we),
        .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata), .mtval_wdata(mtval_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .current_privilege(current_privilege), .mstatus_out(mstatus_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_mstatus();
        logic [31:0] v;
        v = 32'd0;
        v[3] = m_mie;
        v[7] = m_mpie;
        v[12:11] = m_mpp;
        return v;
    endfunction

    task automatic model_reset();
        m_priv = 2'b11; m_mie = 1'b0; m_mpie = 1'b0; m_mpp = 2'b00;
    endtask

    task automatic set_ev(input logic e, input logic r, input logic [3:0] pend, input logic [3:0] en,
                          input logic [31:0] c, input logic [31:0] p, input logic [31:0] t,
                          input logic [31:0] np);
        exc_valid = e; mret_valid = r; irq_pending = pend; irq_enable = en;
        exc_cause = c; exc_pc = p; exc_tval = t; next_pc = np;
    endtask

    // Inputs that must be ignored while the sequencer is busy.
    task automatic scramble();
        set_ev(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
               $urandom & 32'h7fff_ffff, $urandom, $urandom, $urandom);
    endtask

    // Presents the current inputs for one IDLE edge and follows the whole
    // trap sequence, with the pipeline draining after d extra cycles.
    task automatic run_txn(input int d);
        int          kd, idx;
        logic [3:0]  m;
        logic [31:0] c, p, t, tgt, ret_pc;
        kd = K_NONE; c = 0; p = 0; t = 0; idx = 0;
        m = irq_pending & irq_enable;
        if (exc_valid) begin
            kd = K_EXC; c = exc_cause; p = exc_pc; t = exc_tval;
        end else if (m != 0 && (m_mie || m_priv == 2'b00)) begin
            while (!m[idx]) idx++;
            kd = K_IRQ; c = 32'h8000_0000 | 32'(16 + idx); p = next_pc; t = 0;
        end else if (mret_valid) begin
            kd = K_RET;
        end
        if (kd == K_IRQ && mtvec[1:0] == 2'b01)
            tgt = (mtvec & 32'hffff_fffc) + 32'(4 * (16 + idx));
        else
            tgt = mtvec & 32'hffff_fffc;
        ret_pc = mepc;
        tick();
        if (kd == K_NONE) begin
            chk("idle_busy", busy, 0);
            chk("idle_flush", flush, 0);
            return;
        end
        for (int k = 0; k <= d; k++) begin
            chk("drain_flush", flush, 1);
            chk("drain_busy", busy, 1);
            chk("drain_csr_we", csr_we, 0);
            drain_done = (k == d);
            scramble();
            tick();
        end
        if (kd != K_RET) begin
            chk("write_csr_we", csr_we, 1);
            chk("write_flush", flush, 0);
            chk("mepc_wdata", mepc_wdata, p);
            chk("mcause_wdata", mcause_wdata, c);
            chk("mtval_wdata", mtval_wdata, t);
            tick();
            m_mpie = m_mie; m_mie = 1'b0; m_mpp = m_priv; m_priv = 2'b11;
            chk("trap_redirect_valid", redirect_valid, 1);
            chk("trap_redirect_pc", redirect_pc, tgt);
            chk("trap_csr_we_low", csr_we, 0);
            chk("trap_mstatus", mstatus_out, exp_mstatus());
            chk("trap_priv", current_privilege, m_priv);
            tick();
        end else begin
            chk("ret_redirect_valid", redirect_valid, 1);
            chk("ret_redirect_pc", redirect_pc, ret_pc);
            chk("ret_csr_we_low", csr_we, 0);
            tick();
            m_mie = m_mpie; m_mpie = 1'b1; m_priv = m_mpp; m_mpp = 2'b00;
            chk("ret_mstatus", mstatus_out, exp_mstatus());
            chk("ret_priv", current_privilege, m_priv);
        end
        chk("end_busy", busy, 0);
        chk("end_redirect_low", redirect_valid, 0);
    endtask

    initial begin
        rst = 1'b0;
        drain_done = 1'b1;
        mtvec = 32'h8000; mepc = 32'h200;
        set_ev(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_flush", flush, 0);
        chk("rst_csr_we", csr_we, 0);
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_mcause", mcause_wdata, 0);
        chk("rst_priv", current_privilege, 2'b11);
        chk("rst_mstatus", mstatus_out, 0);
        rst = 1'b1;
        tick();

        // MRET from M with MPP=U: drop to U; a second MRET sets MIE from MPIE.
        mepc = 32'h200;
        set_ev(0, 1, 0, 0, 0, 0, 0, 0); run_txn(0);
        set_ev(0, 1, 0, 0, 0, 0, 0, 0); run_txn(0);
        chk("mie_set", mstatus_out[3], 1);

        // Exception together with MRET and an enabled IRQ: exception wins.
        mtvec = 32'h8000;
        set_ev(1, 1, 4'b0001, 4'b1111, 32'd2, 32'h100, 32'hdead, 32'h104); run_txn(0);
        chk("exc_mie_cleared", mstatus_out[3], 0);
        chk("exc_mpie_set", mstatus_out[7], 1);

        // Back to U, then a vectored interrupt.
        mepc = 32'h200;
        set_ev(0, 1, 0, 0, 0, 0, 0, 0); run_txn(0);
        mtvec = 32'h8001;
        set_ev(0, 0, 4'b0110, 4'b1111, 0, 0, 0, 32'h300); run_txn(0);

        // In M with MIE=0 a pending interrupt is not taken; after MRET to U it is.
        set_ev(0, 0, 4'b0001, 4'b0001, 0, 0, 0, 32'h400); run_txn(0);
        chk("masked_priv_m", current_privilege, 2'b11);
        set_ev(0, 1, 4'b0001, 4'b0001, 0, 0, 0, 32'h400); run_txn(0);
        chk("ret_to_u", current_privilege, 2'b00);
        set_ev(0, 0, 4'b0001, 4'b0001, 0, 0, 0, 32'h404); run_txn(0);

        // Long drain.
        mtvec = 32'h9000;
        set_ev(1, 0, 0, 0, 32'd5, 32'h500, 32'h7, 0); run_txn(5);

        // Reset while draining.
        set_ev(1, 0, 0, 0, 32'd3, 32'h600, 0, 0);
        drain_done = 1'b0;
        tick();
        chk("rd_flush", flush, 1);
        rst = 1'b0;
        set_ev(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("rd_busy", busy, 0);
        chk("rd_flush_low", flush, 0);
        rst = 1'b1;
        drain_done = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rd_no_csr_we", csr_we, 0);
            chk("rd_no_redirect", redirect_valid, 0);
        end
        chk("rd_mstatus", mstatus_out, exp_mstatus());
        chk("rd_priv", current_privilege, m_priv);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            mtvec = $urandom;
            mepc = $urandom;
            set_ev(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                   4'($urandom), 4'($urandom), $urandom & 32'h7fff_ffff,
                   $urandom, $urandom, $urandom);
            drain_done = 1'($urandom);
            run_txn($urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
